display_frame_buffer: RTL
=========================

Name: display_frame_buffer

Overview:
- Parametrised double-buffered frame store between the graphics sprite/vector engines (write side) and the display driver (read side).
- Generalises the fixed 640x400, 4-bit double buffer to arbitrary resolution and 1/2/4/8-bit pixels.
- Adds a full read-modify-write pipeline with same-word forwarding, a write ready handshake, and a status-reported, frame-aligned buffer swap.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 400, lines per frame.
- BPP, 4, bits per pixel; legal values 1, 2, 4, 8.
- WORD_WIDTH, 32, RAM word width; must be a multiple of BPP.
- Derived localparams:
  - PIXELS = WIDTH*HEIGHT
  - PPW = WORD_WIDTH/BPP
  - DEPTH = ceil(PIXELS/PPW)
  - ADDR_W = clog2(PIXELS)
  - WADDR_W = clog2(DEPTH)

Ports:
- clock_in  input  1  system clock; the only clock.
- reset_n_in  input  1  reset, asynchronous, active-low.
- pixel_write_address_in  input  ADDR_W  linear pixel index, y*WIDTH+x.
- pixel_write_data_in  input  BPP  pixel value.
- pixel_write_enable_in  input  1  write valid.
- pixel_write_ready_out  output  1  write accepted when enable && ready.
- pixel_read_address_in  input  ADDR_W  display scan pixel index.
- pixel_read_data_out  output  BPP  pixel value, 2-cycle latency.
- switch_write_buffer_in  input  1  swap request, level; rising edge acts.
- switch_pending_out  output  1  swap requested, not yet done.
- displayed_buffer_out  output  1  index of the front buffer (0/1).

Behaviour:
- Reset: async assert clears every register.
  - Outputs: displayed_buffer_out=0, switch_pending_out=0, pixel_read_data_out=0, pixel_write_ready_out=1.
  - Edge monitor=00; write pipeline emptied.
  - RAM contents are not cleared.
  - Reset mid-write: the in-flight write is lost; no partial write occurs after release.
- Storage: two RAMs of DEPTH x WORD_WIDTH, each with one sync read port and one write port.
  - Word address = pixel index / PPW; lane = pixel index % PPW; lane 0 occupies bits [BPP-1:0].
  - Front RAM read port serves the display; back RAM read port serves RMW.
  - Writes only ever target the back buffer (index = !displayed).
- Read path:
  - Cycle 0: address sampled into RAM.
  - Cycle 1: word returns; lane and range flag registered alongside.
  - Cycle 2: pixel_read_data_out registered.
  - Address >= PIXELS returns 0.
  - Buffer selection is taken at cycle 0; a swap never splits a read.
- Write path, 2 stages, throughput 1 pixel/clock:
  - S0: accept; issue back-RAM read of the word.
  - S1: merge the pixel into its lane; write the whole word.
  - Forwarding: if S1 and S0 hit the same word in consecutive cycles, S0 merges into S1's merged word instead of RAM data. Back-to-back writes to one word therefore never lose pixels.
  - Address >= PIXELS: accepted, no RAM write.
- Ready: pixel_write_ready_out = !switch_pending_out (plus the optional-feature term below).
  - Writes presented while ready=0 are ignored and must be held by the producer.
- Swap:
  - The 2-flop edge monitor detects 0->1 on switch_write_buffer_in and sets pending the next cycle.
  - Swap fires when pending && pixel_read_address_in==0 && the write pipeline is empty. On that cycle: displayed toggles and pending clears.
  - A rising edge while already pending is ignored; there is no double swap.
  - A rising edge in the same cycle as the swap is also ignored.
  - Held-high request: exactly one swap.

Optional Feature:
- Macro: DISPLAY_FRAME_BUFFER_CLEAR_ON_SWITCH_EN.
- When defined:
  - After each swap, a WADDR_W counter sweeps the new back buffer, writing word 0 at addresses 0..DEPTH-1, one per cycle.
  - pixel_write_ready_out is 0 during the sweep.
  - A swap request during the sweep stays pending until the sweep ends.
  - Reset aborts the sweep.
- When undefined: no sweep; the back buffer retains the frame from two swaps ago.

Decomposition:
- Shared package display_pkg holds:
  - buffer index enum {BUFFER_A, BUFFER_B};
  - the BPP legality check function;
  - a pixel-to-word/lane split helper.
- One sub-module: display_buffer_ram, a simple dual-port sync-read RAM (DEPTH, WORD_WIDTH), instantiated twice.

Test Plan:
1. Reset with defaults -> ready=1, pending=0, displayed=0, read_data=0.
2. Write addr 9 data 0xA; pulse switch; drive read addr 0 -> swap, displayed=1; then read addr 9 -> 0xA two cycles later; addr 8 -> 0.
3. Writes to addr 8..15 with data 1..8 on consecutive cycles; swap -> reads return 1..8, i.e. word 1 = 0x87654321 (forwarding verified).
4. Switch edge with read addr held at 100 -> pending=1, ready=0 until read addr=0; swap the following cycle; a second edge while pending yields no extra toggle.
5. Write addr 256000 data 0xF; swap -> read 256000 returns 0; all in-range words unchanged.
6. With CLEAR_ON_SWITCH_EN: fill the back buffer with 0x5 and swap -> ready=0 for exactly 32000 cycles; after the next swap every pixel reads 0.

Source files
------------

// File: rtl/display_frame_buffer_pkg.sv
// Shared types and helpers for the display frame buffer.
//   buffer_e      : which of the two frame RAMs is meant (A = 0, B = 1)
//   bpp_is_legal  : pixel depths the buffer supports (1, 2, 4, 8)
//   pixel_word    : linear pixel index -> RAM word address
//   pixel_lane    : linear pixel index -> pixel slot inside that word
package display_pkg;

    typedef enum logic {
        BUFFER_A = 1'b0,
        BUFFER_B = 1'b1
    } buffer_e;

    function automatic bit bpp_is_legal(input int unsigned bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
    endfunction

    // Word/lane split of a pixel index; lane 0 sits in the low bits of the word.
    function automatic logic [31:0] pixel_word(input logic [31:0] idx, input int unsigned ppw);
        return idx / ppw;
    endfunction

    function automatic logic [31:0] pixel_lane(input logic [31:0] idx, input int unsigned ppw);
        return idx % ppw;
    endfunction

endpackage

// File: rtl/display_frame_buffer_if.sv
// Pixel write / display read / swap-control bundle of the display frame buffer.
//   slave  : the frame buffer (takes writes, read addresses and swap requests)
//   master : the drawing engines and display driver side
interface display_frame_buffer_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned BPP    = 4
);

    logic [ADDR_W-1:0] pixel_write_address_in;
    logic [BPP-1:0]    pixel_write_data_in;
    logic              pixel_write_enable_in;
    logic              pixel_write_ready_out;
    logic [ADDR_W-1:0] pixel_read_address_in;
    logic [BPP-1:0]    pixel_read_data_out;
    logic              switch_write_buffer_in;
    logic              switch_pending_out;
    logic              displayed_buffer_out;

    modport slave (
        input  pixel_write_address_in,
        input  pixel_write_data_in,
        input  pixel_write_enable_in,
        output pixel_write_ready_out,
        input  pixel_read_address_in,
        output pixel_read_data_out,
        input  switch_write_buffer_in,
        output switch_pending_out,
        output displayed_buffer_out
    );

    modport master (
        output pixel_write_address_in,
        output pixel_write_data_in,
        output pixel_write_enable_in,
        input  pixel_write_ready_out,
        output pixel_read_address_in,
        input  pixel_read_data_out,
        output switch_write_buffer_in,
        input  switch_pending_out,
        input  displayed_buffer_out
    );

endinterface

// File: rtl/display_buffer_ram.sv
// One frame RAM: simple dual-port, one synchronous read port and one write port.
// A read and a write to the same word in the same cycle return the old word.
//   clock_in      : clock
//   write_enable  : write strobe
//   write_address : word written
//   write_data    : word value
//   read_address  : word read
//   read_data     : registered read word, valid the cycle after the address
module display_buffer_ram #(
    parameter int unsigned DEPTH      = 32000,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                  clock_in,
    input  logic                  write_enable,
    input  logic [ADDR_W-1:0]     write_address,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic [ADDR_W-1:0]     read_address,
    output logic [WORD_WIDTH-1:0] read_data
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; contents survive reset by design.
    always_ff @(posedge clock_in) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        read_data <= mem[read_address];
    end

endmodule

// File: rtl/display_frame_buffer.sv
// Double-buffered frame store between the drawing engines (write side) and the
// display driver (read side).
//   clock_in   : clock
//   reset_n_in : asynchronous active-low reset
//   bus        : pixel write handshake, display read address/data, swap control
// Writes are read-modify-write on the back buffer (2-stage pipeline, one pixel
// per clock, same-word forwarding). Display reads return after two cycles.
// A swap request takes effect when the display scan is at pixel 0 and the write
// pipeline has drained.
// Build option DISPLAY_FRAME_BUFFER_CLEAR_ON_SWITCH_EN: after every swap the new
// back buffer is swept to zero, one word per cycle, with writes stalled.
module display_frame_buffer
    import display_pkg::*;
#(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 400,
    parameter int unsigned BPP        = 4,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    display_frame_buffer_if.slave bus
);

    localparam int unsigned PIXELS  = WIDTH * HEIGHT;
    localparam int unsigned PPW     = WORD_WIDTH / BPP;
    localparam int unsigned DEPTH   = (PIXELS + PPW - 1) / PPW;
    localparam int unsigned ADDR_W  = $clog2(PIXELS);
    localparam int unsigned WADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LANE_W  = (PPW > 1) ? $clog2(PPW) : 1;

    if (!bpp_is_legal(BPP) || ((WORD_WIDTH % BPP) != 0) || (ADDR_W > 32)) begin : g_cfg_error
        $error("display_frame_buffer: unsupported BPP / WORD_WIDTH / resolution");
    end

    // ---------------- control state ----------------
    logic [1:0] sw_q;
    logic       pending_q, pending_d;
    logic       ready_q, ready_d;
    buffer_e    displayed_q, back_buf;
    logic       edge_rise, swap_fire;
    logic       sweep_active, sweep_d;
    logic [WADDR_W-1:0] sweep_addr;

    // ---------------- read path ----------------
    logic               rd_inrange, rd_inrange_q;
    logic [WADDR_W-1:0] rd_waddr;
    logic [LANE_W-1:0]  rd_lane, rd_lane_q;
    buffer_e            rd_buf_q;
    logic [WORD_WIDTH-1:0] rd_word;
    logic [BPP-1:0]     rd_pix, read_data_d, read_data_q;

    // ---------------- write pipeline ----------------
    logic               accept;
    logic               wr_inrange;
    logic [WADDR_W-1:0] wr_waddr;
    logic [LANE_W-1:0]  wr_lane;
    logic               p_valid_q, p_inrange_q;
    logic [WADDR_W-1:0] p_waddr_q;
    logic [LANE_W-1:0]  p_lane_q;
    logic [BPP-1:0]     p_data_q;
    logic               fwd_d, fwd_q;
    logic [WORD_WIDTH-1:0] back_rdata, merge_base, merged, merged_q;

    // ---------------- RAM ports ----------------
    logic [WORD_WIDTH-1:0] rdata_a, rdata_b;
    logic [WADDR_W-1:0]    raddr_a, raddr_b;
    logic                  we_any, we_a, we_b;
    logic [WADDR_W-1:0]    ram_waddr;
    logic [WORD_WIDTH-1:0] ram_wdata;

    // Address decode for both ports; out-of-range indices are parked on word 0.
    assign rd_inrange = 32'(bus.pixel_read_address_in) < PIXELS;
    assign rd_waddr   = rd_inrange ? WADDR_W'(pixel_word(32'(bus.pixel_read_address_in), PPW)) : '0;
    assign rd_lane    = LANE_W'(pixel_lane(32'(bus.pixel_read_address_in), PPW));

    assign wr_inrange = 32'(bus.pixel_write_address_in) < PIXELS;
    assign wr_waddr   = wr_inrange ? WADDR_W'(pixel_word(32'(bus.pixel_write_address_in), PPW)) : '0;
    assign wr_lane    = LANE_W'(pixel_lane(32'(bus.pixel_write_address_in), PPW));

    assign back_buf  = (displayed_q == BUFFER_A) ? BUFFER_B : BUFFER_A;
    assign accept    = bus.pixel_write_enable_in && ready_q;
    assign edge_rise = sw_q[0] && !sw_q[1];
    assign swap_fire = pending_q && (bus.pixel_read_address_in == '0) && !p_valid_q && !sweep_active;

    // Forward when the word just merged is hit again by the write being accepted now.
    assign fwd_d = accept && wr_inrange && p_valid_q && p_inrange_q && (wr_waddr == p_waddr_q);

    // Swap request, sweep and ready next-state.
    always_comb begin
        pending_d = pending_q;
        sweep_d   = 1'b0;
        if (pending_q) begin
            if (swap_fire) begin
                pending_d = 1'b0;
            end
        end else if (edge_rise) begin
            pending_d = 1'b1;
        end
`ifdef DISPLAY_FRAME_BUFFER_CLEAR_ON_SWITCH_EN
        sweep_d = sweep_active;
        if (swap_fire) begin
            sweep_d = 1'b1;
        end else if (sweep_active && (sweep_addr == WADDR_W'(DEPTH - 1))) begin
            sweep_d = 1'b0;
        end
`endif
        ready_d = !pending_d && !sweep_d;
    end

`ifdef DISPLAY_FRAME_BUFFER_CLEAR_ON_SWITCH_EN
    // Zero sweep of the freshly exposed back buffer.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sweep_active <= 1'b0;
            sweep_addr   <= '0;
        end else begin
            sweep_active <= sweep_d;
            if (swap_fire) begin
                sweep_addr <= '0;
            end else if (sweep_active) begin
                sweep_addr <= sweep_addr + WADDR_W'(1);
            end
        end
    end
`else
    assign sweep_active = 1'b0;
    assign sweep_addr   = '0;
`endif

    // Merge the pending pixel into its word, from RAM or from the previous merge.
    always_comb begin
        back_rdata = (back_buf == BUFFER_A) ? rdata_a : rdata_b;
        merge_base = fwd_q ? merged_q : back_rdata;
        merged     = merge_base;
        for (int unsigned l = 0; l < PPW; l++) begin
            if (p_lane_q == LANE_W'(l)) begin
                merged[l*BPP +: BPP] = p_data_q;
            end
        end
    end

    // RAM port steering: front RAM reads for the display, back RAM for RMW and writes.
    always_comb begin
        raddr_a   = (displayed_q == BUFFER_A) ? rd_waddr : wr_waddr;
        raddr_b   = (displayed_q == BUFFER_B) ? rd_waddr : wr_waddr;
        we_any    = (p_valid_q && p_inrange_q) || sweep_active;
        we_a      = we_any && (back_buf == BUFFER_A);
        we_b      = we_any && (back_buf == BUFFER_B);
        ram_waddr = sweep_active ? sweep_addr : p_waddr_q;
        ram_wdata = sweep_active ? '0 : merged;
    end

    // Display pixel extraction from the buffer chosen when the address was sampled.
    always_comb begin
        rd_word = (rd_buf_q == BUFFER_A) ? rdata_a : rdata_b;
        rd_pix  = '0;
        for (int unsigned l = 0; l < PPW; l++) begin
            if (rd_lane_q == LANE_W'(l)) begin
                rd_pix = rd_word[l*BPP +: BPP];
            end
        end
        read_data_d = rd_inrange_q ? rd_pix : '0;
    end

    // Control, read pipeline and write pipeline registers.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sw_q         <= 2'b00;
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            displayed_q  <= BUFFER_A;
            rd_lane_q    <= '0;
            rd_inrange_q <= 1'b0;
            rd_buf_q     <= BUFFER_A;
            read_data_q  <= '0;
            p_valid_q    <= 1'b0;
            p_inrange_q  <= 1'b0;
            p_waddr_q    <= '0;
            p_lane_q     <= '0;
            p_data_q     <= '0;
            fwd_q        <= 1'b0;
            merged_q     <= '0;
        end else begin
            sw_q         <= {sw_q[0], bus.switch_write_buffer_in};
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            if (swap_fire) begin
                displayed_q <= back_buf;
            end
            rd_lane_q    <= rd_lane;
            rd_inrange_q <= rd_inrange;
            rd_buf_q     <= displayed_q;
            read_data_q  <= read_data_d;
            p_valid_q    <= accept;
            if (accept) begin
                p_inrange_q <= wr_inrange;
                p_waddr_q   <= wr_waddr;
                p_lane_q    <= wr_lane;
                p_data_q    <= bus.pixel_write_data_in;
            end
            fwd_q        <= fwd_d;
            merged_q     <= merged;
        end
    end

    display_buffer_ram #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_W     (WADDR_W)
    ) u_ram_a (
        .clock_in      (clock_in),
        .write_enable  (we_a),
        .write_address (ram_waddr),
        .write_data    (ram_wdata),
        .read_address  (raddr_a),
        .read_data     (rdata_a)
    );

    display_buffer_ram #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_W     (WADDR_W)
    ) u_ram_b (
        .clock_in      (clock_in),
        .write_enable  (we_b),
        .write_address (ram_waddr),
        .write_data    (ram_wdata),
        .read_address  (raddr_b),
        .read_data     (rdata_b)
    );

    assign bus.pixel_write_ready_out = ready_q;
    assign bus.pixel_read_data_out   = read_data_q;
    assign bus.switch_pending_out    = pending_q;
    assign bus.displayed_buffer_out  = displayed_q;

endmodule
